// File: rtl/popcount_pipe_if.sv
// Stream interface for the pipelined population counter: input beat side,
// output count side, each with its own valid/ready pair.
interface popcount_pipe_if #(
    parameter int NUM_INPUTS = 8
);
    localparam int SUM_WIDTH = $clog2(NUM_INPUTS + 1);

    logic [NUM_INPUTS-1:0] in_bits;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [SUM_WIDTH-1:0]  sum;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_bits, in_last, in_valid, out_ready,
        input  in_ready, sum, out_last, out_valid
    );

    modport slave (
        input  in_bits, in_last, in_valid, out_ready,
        output in_ready, sum, out_last, out_valid
    );
endinterface

// File: rtl/popcount_pipe.sv
// Pipelined population counter: registered binary adder tree, one register
// stage per tree level, all stages advancing together under one enable.
module popcount_pipe #(
    parameter int NUM_INPUTS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    popcount_pipe_if.slave bus
);
    localparam int SUM_WIDTH = $clog2(NUM_INPUTS + 1);
    localparam int LATENCY   = $clog2(NUM_INPUTS);

    if (NUM_INPUTS < 2 || NUM_INPUTS > 64) begin : g_bad_param
        $error("popcount_pipe: NUM_INPUTS must be within 2..64");
    end

    // Number of nodes at tree level k is ceil(NUM_INPUTS / 2^k).
    function automatic int level_count(input int k);
        return (NUM_INPUTS + (1 << k) - 1) >> k;
    endfunction

    logic adv;
    logic out_valid_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    genvar k, j;
    for (k = 1; k <= LATENCY; k++) begin : g_lvl
        localparam int NP = level_count(k - 1);
        localparam int NC = level_count(k);
        localparam int WP = k;
        localparam int WC = k + 1;

        logic [NP*WP-1:0] prev;
        logic             prev_vld;
        logic             prev_last;
        logic [NC*WC-1:0] nxt;
        logic [NC*WC-1:0] q;
        logic             vld_q;
        logic             last_q;

        if (k == 1) begin : g_src_in
            assign prev      = bus.in_bits;
            assign prev_vld  = bus.in_valid;
            assign prev_last = bus.in_last;
        end else begin : g_src_lvl
            assign prev      = g_lvl[k-1].q;
            assign prev_vld  = g_lvl[k-1].vld_q;
            assign prev_last = g_lvl[k-1].last_q;
        end

        for (j = 0; j < NC; j++) begin : g_node
            if (2 * j + 1 < NP) begin : g_pair
                assign nxt[j*WC +: WC] = WC'(prev[2*j*WP +: WP])
                                       + WC'(prev[(2*j+1)*WP +: WP]);
            end else begin : g_pass
                assign nxt[j*WC +: WC] = WC'(prev[2*j*WP +: WP]);
            end
        end

        // Bubbles load zeros so don't-care input data never reaches the output.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q      <= '0;
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end else if (adv) begin
                q      <= prev_vld ? nxt : '0;
                vld_q  <= prev_vld;
                last_q <= prev_vld & prev_last;
            end
        end
    end

    // The last tree level may be one bit wider than the count ever needs.
    if (LATENCY + 1 > SUM_WIDTH) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^g_lvl[LATENCY].q[LATENCY:SUM_WIDTH];
    end

    assign out_valid_q   = g_lvl[LATENCY].vld_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = g_lvl[LATENCY].last_q;
    assign bus.sum       = g_lvl[LATENCY].q[SUM_WIDTH-1:0];
endmodule

// File: tb/tb_popcount_pipe.sv
// Self-checking bench for popcount_pipe: 8-input instance against a queue
// reference model, plus a 5-input instance for the odd-width tree.
module tb_popcount_pipe;
    localparam int LAT8 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    popcount_pipe_if #(.NUM_INPUTS(8)) b8 ();
    popcount_pipe_if #(.NUM_INPUTS(5)) b5 ();

    popcount_pipe #(.NUM_INPUTS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    popcount_pipe #(.NUM_INPUTS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int cnt;
        bit last;
    } beat_t;

    typedef struct {
        int sum;
        bit last;
        int cyc;
    } obs_t;

    beat_t model_q[$];
    obs_t  obs8[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: every accepted beat queues its popcount; every output
    // handshake must present the oldest queued beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            chk("in_ready", 32'(b8.in_ready), 32'(!b8.out_valid || b8.out_ready));
            if (b8.out_valid) begin
                if (model_q.size() == 0) begin
                    chk("spurious_valid", 32'(b8.out_valid), 32'd0);
                end else begin
                    chk("sum", 32'(b8.sum), 32'(model_q[0].cnt));
                    chk("out_last", 32'(b8.out_last), 32'(model_q[0].last));
                    if (b8.out_ready) begin
                        obs8.push_back('{int'(b8.sum), b8.out_last, cyc});
                        void'(model_q.pop_front());
                    end
                end
            end
            if (b8.in_valid && b8.in_ready)
                model_q.push_back('{$countones(b8.in_bits), b8.in_last});
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send8(input logic [7:0] bits, input logic last);
        logic acc;
        int   n;
        n = 0;
        b8.in_bits  = bits;
        b8.in_last  = last;
        b8.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = b8.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        b8.in_valid = 1'b0;
        b8.in_last  = 1'b0;
        b8.in_bits  = 8'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send5_check(input logic [4:0] bits, input string tag);
        int n;
        b5.in_bits  = bits;
        b5.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b5.in_valid = 1'b0;
        b5.in_bits  = 5'($urandom);
        n = 0;
        while (!b5.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(b5.out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk(tag, 32'(b5.sum), 32'($countones(bits)));
        cycles(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st_bits [5];
        int         st_exp  [5];
        int         s0;

        st_bits = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h0F};
        st_exp  = '{0, 8, 1, 1, 4};

        rst_n        = 1'b0;
        b8.in_bits   = '0;
        b8.in_last   = 1'b0;
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b0;
        b5.in_bits   = '0;
        b5.in_last   = 1'b0;
        b5.in_valid  = 1'b0;
        b5.out_ready = 1'b1;

        cycles(2);
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_sum", 32'(b8.sum), 32'd0);
        chk("rst_out_last", 32'(b8.out_last), 32'd0);
        chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
        chk("rst5_out_valid", 32'(b5.out_valid), 32'd0);
        rst_n        = 1'b1;
        b8.out_ready = 1'b1;
        cycles(1);

        // Single beat: valid after edge t+LATENCY-1, for one cycle only.
        send8(8'b1011_0010, 1'b0);
        chk("lat_t0", 32'(b8.out_valid), 32'd0);
        cycles(1);
        chk("lat_t1", 32'(b8.out_valid), 32'd0);
        cycles(1);
        chk("lat_t2", 32'(b8.out_valid), 32'd1);
        chk("lat_sum", 32'(b8.sum), 32'd4);
        cycles(1);
        chk("lat_t3", 32'(b8.out_valid), 32'd0);

        // Back-to-back stream with LAST on the final beat.
        obs8.delete();
        for (int i = 0; i < 5; i++) send8(st_bits[i], i == 4);
        cycles(LAT8 + 2);
        chk("stream_n", 32'(obs8.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs8.size()) begin
                chk("stream_sum", 32'(obs8[i].sum), 32'(st_exp[i]));
                chk("stream_last", 32'(obs8[i].last), 32'(i == 4));
                if (i > 0) chk("stream_gap", 32'(obs8[i].cyc - obs8[i-1].cyc), 32'd1);
            end
        end

        // Backpressure: stall three cycles with output valid, a fifth beat waiting.
        obs8.delete();
        for (int i = 0; i < 4; i++) send8(8'($urandom), 1'b0);
        b8.out_ready = 1'b0;
        #1;
        chk("bp_valid", 32'(b8.out_valid), 32'd1);
        s0 = int'(b8.sum);
        fork
            send8(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    cycles(1);
                    chk("bp_in_ready", 32'(b8.in_ready), 32'd0);
                    chk("bp_sum_hold", 32'(b8.sum), 32'(s0));
                end
                b8.out_ready = 1'b1;
            end
        join
        cycles(LAT8 + 3);
        chk("bp_n", 32'(obs8.size()), 32'd5);
        if (obs8.size() == 5) chk("bp_fifth", 32'(obs8[4].sum), 32'd4);

        // Reset with two beats in flight: neither may emerge.
        obs8.delete();
        send8(8'hFF, 1'b0);
        send8(8'h3C, 1'b1);
        rst_n = 1'b0;
        cycles(1);
        chk("mid_rst_valid", 32'(b8.out_valid), 32'd0);
        rst_n = 1'b1;
        cycles(2);
        chk("mid_rst_idle", 32'(obs8.size()), 32'd0);
        send8(8'h07, 1'b0);
        cycles(LAT8 + 1);
        chk("post_rst_n", 32'(obs8.size()), 32'd1);
        if (obs8.size() == 1) chk("post_rst_sum", 32'(obs8[0].sum), 32'd3);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            b8.in_valid  = ($urandom_range(0, 3) != 0);
            b8.in_bits   = 8'($urandom);
            b8.in_last   = 1'($urandom);
            b8.out_ready = ($urandom_range(0, 3) != 0);
            if (i % 50 == 0) b8.in_bits = (i % 100 == 0) ? 8'hFF : 8'h00;
            cycles(1);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        cycles(LAT8 + 3);
        chk("drain_empty", 32'(model_q.size()), 32'd0);
        chk("drain_valid", 32'(b8.out_valid), 32'd0);

        // Odd-width tree, including the unpaired passthrough node.
        send5_check(5'b11111, "odd_all1");
        send5_check(5'b10000, "odd_top");
        send5_check(5'b00000, "odd_all0");
        for (int i = 0; i < 6; i++) send5_check(5'($urandom), "odd_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, pipelined population counter: sums NUM_INPUTS 1-bit inputs into an unsigned count.
- Generalises the 1-bit + 1-bit -> 2-bit adder to an N-input registered adder tree with valid/ready flow control and a LAST sideband.
- Sits in front of the Conway rule logic. With the default NUM_INPUTS=8 it counts live neighbours, one cell per accepted beat.

Parameters:
- NUM_INPUTS, 8, number of 1-bit inputs summed. Legal range 2..64; anything else is a elaboration-time $error.
- SUM_WIDTH, $clog2(NUM_INPUTS+1), derived (localparam, not overridable): output count width. Default is 4.
- LATENCY, $clog2(NUM_INPUTS), derived (localparam): number of register stages, one per adder-tree level. Default is 3.

Ports:
- CLK, input, 1, rising-edge clock.
- RST_N, input, 1, synchronous active-low reset.
- IN_BITS, input, NUM_INPUTS, bits to be counted.
- IN_LAST, input, 1, sideband flag (end of row). Carried alongside the data unchanged.
- IN_VALID, input, 1, IN_BITS and IN_LAST are valid.
- IN_READY, output, 1, pipeline accepts a beat this cycle.
- SUM, output, SUM_WIDTH, number of 1s in the accepted IN_BITS.
- OUT_LAST, output, 1, IN_LAST of the same beat.
- OUT_VALID, output, 1, SUM and OUT_LAST are valid.
- OUT_READY, input, 1, downstream accepts the output.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - All stage valid bits clear; OUT_VALID=0, SUM=0, OUT_LAST=0.
  - IN_READY=1 on the cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial output is ever produced.
- Tree structure:
  - Level k (1..LATENCY) adds adjacent pairs from level k-1. Each level's results are registered.
  - An unpaired odd element passes through zero-extended to the level width.
  - Level k width is k+1 bits. The final level is truncated/extended to SUM_WIDTH, with no loss of value since the maximum is NUM_INPUTS.
- Stage valid: each stage holds a valid bit; stage k registers data from stage k-1 together with its valid bit and LAST.
- Global advance enable: ADV = !OUT_VALID || OUT_READY.
  - ADV=1: every stage shifts forward one position.
  - ADV=0: every stage holds its contents.
- IN_READY = ADV (purely combinational from OUT_VALID/OUT_READY). A beat is accepted when IN_VALID && IN_READY.
- Bubbles: when IN_VALID=0 while ADV=1, a bubble (valid=0) enters stage 1. Bubbles are not compressed.
- Latency and throughput: a beat accepted at edge t appears with OUT_VALID=1 after edge t+LATENCY-1, i.e. LATENCY cycles with no stall. Sustained throughput is 1 beat/cycle when OUT_READY is held at 1.
- Output stability: while OUT_VALID=1 && OUT_READY=0, SUM and OUT_LAST stay stable and no new beat is accepted.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Boundary values:
  - IN_BITS all 0 gives SUM=0.
  - IN_BITS all 1 gives SUM=NUM_INPUTS, with no overflow.
- IN_BITS and IN_LAST are don't-care when IN_VALID=0. X on them must not propagate into SUM while the output is valid.

Test Plan:
- Reset, NUM_INPUTS=8: hold RST_N=0 for 2 cycles → OUT_VALID=0, SUM=0, IN_READY=1.
- Single beat, OUT_READY=1: IN_BITS=8'b1011_0010 accepted at edge t → SUM=4 and OUT_VALID=1 exactly 3 cycles later for one cycle, then OUT_VALID=0.
- Back-to-back stream: IN_BITS=0x00, 0xFF, 0x01, 0x80, 0x0F on consecutive cycles, OUT_READY=1 → SUM=0, 8, 1, 1, 4 on consecutive cycles. IN_LAST=1 on the 5th beat only → OUT_LAST=1 on the 5th output only.
- Backpressure: stream 4 beats, drop OUT_READY for 3 cycles while OUT_VALID=1 → SUM stable and IN_READY=0 during the stall. After release all 4 sums arrive in order with none lost.
- Reset mid-flight: accept 2 beats, assert RST_N=0 one cycle later → OUT_VALID never rises for those beats. The next beat after reset (0x07) gives SUM=3.
- Odd width, NUM_INPUTS=5 (LATENCY=3, SUM_WIDTH=3): IN_BITS=5'b11111 → SUM=5. IN_BITS=5'b10000 → SUM=1, exercising the odd passthrough path.
